fmul_pipe: RTL



---
 rtl/fmul_pkg.sv | 21 ++
 rtl/fmul_round.sv | 81 ++++++++
 rtl/fmul_pipe.sv | 135 +++++++++++++
 3 files changed

// File: rtl/fmul_pkg.sv
// fmul_pkg: flag indices, operand classes and bias helper
// shared by the pipelined floating-point multiplier.
package fmul_pkg;

   localparam int FLAG_INVALID   = 3;
   localparam int FLAG_OVERFLOW  = 2;
   localparam int FLAG_UNDERFLOW = 1;
   localparam int FLAG_INEXACT   = 0;

   typedef enum logic [1:0] {
      ZERO,
      NORMAL,
      INF,
      NAN
   } cls_t;

   function automatic int bias(input int exp_w);
      return (1 << (exp_w - 1)) - 1;
   endfunction

endpackage

// File: rtl/fmul_round.sv
// fmul_round: normalise, round-to-nearest-even, range check, pack.
// FMUL_PIPE_FLAGS_EN adds the exception flag output.
module fmul_round
   import fmul_pkg::*;
#(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  cls_t                     cls,
   input  logic                     sign,
   input  logic signed [EXP_W+1:0]  esum,
   input  logic [2*MAN_W+1:0]       prod,
   output logic [EXP_W+MAN_W:0]     res
`ifdef FMUL_PIPE_FLAGS_EN
   ,
   output logic [3:0]               flg
`endif
);

   localparam int PW = 2*MAN_W+2;
   localparam logic signed [EXP_W+1:0] EMAX =
      (EXP_W+2)'((1 << EXP_W) - 1);
   localparam logic signed [EXP_W+1:0] EZERO = '0;

   logic                    norm;
   logic [MAN_W-1:0]        man;
   logic                    g;
   logic                    st;
   logic                    rup;
   logic [MAN_W:0]          mr;
   logic signed [EXP_W+1:0] e;
   logic                    ovf;
   logic                    unf;

   always_comb begin
      norm = prod[PW-1];
      if (norm) begin
         man = prod[PW-2:MAN_W+1];
         g   = prod[MAN_W];
         st  = |prod[MAN_W-1:0];
      end else begin
         man = prod[PW-3:MAN_W];
         g   = prod[MAN_W-1];
         st  = |prod[MAN_W-2:0];
      end
      rup = g & (st | man[0]);
      mr  = {1'b0, man} + (MAN_W+1)'(rup);
      // a carry out leaves the fraction all-zero, so only E moves
      e   = esum + (EXP_W+2)'(norm) + (EXP_W+2)'(mr[MAN_W]);
      ovf = (e >= EMAX);
      unf = (e <= EZERO);
      res = '0;
      unique case (cls)
         NAN:  res = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
         INF:  res = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         ZERO: res = {sign, {(EXP_W+MAN_W){1'b0}}};
         default: begin
            if (ovf)
               res = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            else if (unf)
               res = {sign, {(EXP_W+MAN_W){1'b0}}};
            else
               res = {sign, e[EXP_W-1:0], mr[MAN_W-1:0]};
         end
      endcase
   end

`ifdef FMUL_PIPE_FLAGS_EN
   always_comb begin
      flg = '0;
      if (cls == NAN) begin
         flg[FLAG_INVALID] = 1'b1;
      end else if (cls == NORMAL) begin
         flg[FLAG_OVERFLOW]  = ovf;
         flg[FLAG_UNDERFLOW] = unf;
         flg[FLAG_INEXACT]   = g | st | ovf | unf;
      end
   end
`endif

endmodule

// File: rtl/fmul_pipe.sv
// fmul_pipe: 3-stage floating-point multiplier with valid/ready.
// FMUL_PIPE_FLAGS_EN adds the {invalid,overflow,underflow,inexact} port.
module fmul_pipe
   import fmul_pkg::*;
#(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [EXP_W+MAN_W:0] x1,
   input  logic [EXP_W+MAN_W:0] x2,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [EXP_W+MAN_W:0] y
`ifdef FMUL_PIPE_FLAGS_EN
   ,
   output logic [3:0]           flags
`endif
);

   localparam int W = 1+EXP_W+MAN_W;
   localparam logic [EXP_W+1:0] BIAS = (EXP_W+2)'(bias(EXP_W));

   typedef struct packed {
      cls_t             cls;
      logic             sign;
      logic [EXP_W+1:0] esum;
      logic [MAN_W:0]   ma;
      logic [MAN_W:0]   mb;
   } s1_t;

   typedef struct packed {
      cls_t               cls;
      logic               sign;
      logic [EXP_W+1:0]   esum;
      logic [2*MAN_W+1:0] prod;
   } s2_t;

   function automatic cls_t classify(
      input logic [EXP_W-1:0] e,
      input logic [MAN_W-1:0] m
   );
      if (e == '0)
         return ZERO;
      else if (e != '1)
         return NORMAL;
      else if (m == '0)
         return INF;
      else
         return NAN;
   endfunction

   logic               en;
   logic               v1, v2, v3;
   s1_t                n1, r1;
   s2_t                r2;
   cls_t               c1, c2;
   logic [2*MAN_W+1:0] prod;
   logic [W-1:0]       res;

   assign en        = out_ready | ~v3;
   assign in_ready  = en;
   assign out_valid = v3;

   always_comb begin
      c1      = classify(x1[W-2:MAN_W], x1[MAN_W-1:0]);
      c2      = classify(x2[W-2:MAN_W], x2[MAN_W-1:0]);
      n1.sign = x1[W-1] ^ x2[W-1];
      n1.esum = {2'b00, x1[W-2:MAN_W]} + {2'b00, x2[W-2:MAN_W]} - BIAS;
      n1.ma   = {1'b1, x1[MAN_W-1:0]};
      n1.mb   = {1'b1, x2[MAN_W-1:0]};
      n1.cls  = NORMAL;
      priority case (1'b1)
         (c1 == NAN) || (c2 == NAN): n1.cls = NAN;
         (c1 == INF) && (c2 == ZERO): n1.cls = NAN;
         (c1 == ZERO) && (c2 == INF): n1.cls = NAN;
         (c1 == INF) || (c2 == INF): n1.cls = INF;
         (c1 == ZERO) || (c2 == ZERO): n1.cls = ZERO;
         default: n1.cls = NORMAL;
      endcase
   end

   assign prod = {{(MAN_W+1){1'b0}}, r1.ma} * {{(MAN_W+1){1'b0}}, r1.mb};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1 <= 1'b0;
         v2 <= 1'b0;
         v3 <= 1'b0;
         r1 <= '0;
         r2 <= '0;
         y  <= '0;
      end else if (en) begin
         v1      <= in_valid;
         r1      <= n1;
         v2      <= v1;
         r2.cls  <= r1.cls;
         r2.sign <= r1.sign;
         r2.esum <= r1.esum;
         r2.prod <= prod;
         v3      <= v2;
         y       <= res;
      end
   end

`ifdef FMUL_PIPE_FLAGS_EN
   logic [3:0] flg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         flags <= '0;
      else if (en)
         flags <= flg;
   end
`endif

   fmul_round #(
      .EXP_W(EXP_W),
      .MAN_W(MAN_W)
   ) u_round (
      .cls  (r2.cls),
      .sign (r2.sign),
      .esum (r2.esum),
      .prod (r2.prod),
      .res  (res)
`ifdef FMUL_PIPE_FLAGS_EN
      ,
      .flg  (flg)
`endif
   );

endmodule
